// File: rtl/param_cache_pkg.sv
// param_cache_pkg: shared types and helpers for the direct-mapped cache.
// Imported by the cache top and its storage sub-module.
package param_cache_pkg;

  typedef enum logic [1:0] {
    IDLE,
    EVICT,
    FILL,
    WTHRU
  } state_t;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction

endpackage

// File: rtl/param_cache_if.sv
// param_cache_if: CPU word port and line-wide memory port bundles.
// CPU side: master = datapath, slave = cache. Memory side: master = cache.
interface param_cache_cpu_if #(
  parameter int WORD_SIZE = 16
);
  logic                 readC;
  logic                 writeC;
  logic [WORD_SIZE-1:0] address;
  logic [WORD_SIZE-1:0] data_in;
  logic [WORD_SIZE-1:0] data_out;
  logic                 readyC;

  modport master (
    output readC, writeC, address, data_in,
    input  data_out, readyC
  );
  modport slave (
    input  readC, writeC, address, data_in,
    output data_out, readyC
  );
endinterface

interface param_cache_mem_if #(
  parameter int WORD_SIZE  = 16,
  parameter int LINE_WORDS = 4
);
  localparam int LINE_W = LINE_WORDS * WORD_SIZE;

  logic                 readM;
  logic                 writeM;
  logic [WORD_SIZE-1:0] addressM;
  logic [LINE_W-1:0]    dataM_out;
  logic [LINE_W-1:0]    dataM_in;
  logic                 readyM;

  modport master (
    output readM, writeM, addressM, dataM_out,
    input  dataM_in, readyM
  );
  modport slave (
    input  readM, writeM, addressM, dataM_out,
    output dataM_in, readyM
  );
endinterface

// File: rtl/param_cache_store.sv
// param_cache_store: tag/valid/dirty/data arrays of the cache.
// One line write port with per-word enables; data arrays are never cleared.
module param_cache_store
  import param_cache_pkg::*;
#(
  parameter int WORD_SIZE  = 16,
  parameter int LINE_WORDS = 4,
  parameter int NUM_LINES  = 4,
  parameter int IDX_W      = 2,
  parameter int TAG_W      = 12,
  parameter int LINE_W     = LINE_WORDS * WORD_SIZE
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [IDX_W-1:0]      idx,
  input  logic [LINE_WORDS-1:0] word_we,
  input  logic [LINE_W-1:0]     wdata,
  input  logic                  tag_we,
  input  logic [TAG_W-1:0]      tag_in,
  input  logic                  dirty_we,
  input  logic                  dirty_in,
  output logic [TAG_W-1:0]      tag,
  output logic                  valid,
  output logic                  dirty,
  output logic [LINE_W-1:0]     line
);

  logic [LINE_W-1:0]    data_q [NUM_LINES];
  logic [TAG_W-1:0]     tag_q  [NUM_LINES];
  logic [NUM_LINES-1:0] valid_q;
  logic [NUM_LINES-1:0] dirty_q;

  always_ff @(posedge clk) begin
    for (int k = 0; k < LINE_WORDS; k++) begin
      if (word_we[k]) begin
        data_q[idx][k*WORD_SIZE +: WORD_SIZE] <=
          wdata[k*WORD_SIZE +: WORD_SIZE];
      end
    end
    if (tag_we) tag_q[idx] <= tag_in;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      valid_q <= '0;
      dirty_q <= '0;
    end else begin
      if (tag_we)   valid_q[idx] <= 1'b1;
      if (dirty_we) dirty_q[idx] <= dirty_in;
    end
  end

  assign tag   = tag_q[idx];
  assign valid = valid_q[idx];
  assign dirty = dirty_q[idx];
  assign line  = data_q[idx];

endmodule

// File: rtl/param_cache.sv
// param_cache: direct-mapped word cache in front of a line-wide memory.
// Write-back or write-through, both write-allocate; CPU stalls on readyC.
module param_cache
  import param_cache_pkg::*;
#(
  parameter int WORD_SIZE  = 16,
  parameter int LINE_WORDS = 4,
  parameter int NUM_LINES  = 4,
  parameter bit WRITE_BACK = 1'b1,
  parameter int CNT_W      = 16
) (
  input  logic              clk,
  input  logic              reset_n,
  param_cache_cpu_if.slave  cpu,
  param_cache_mem_if.master mem,
  output logic [CNT_W-1:0]  access_cnt,
  output logic [CNT_W-1:0]  miss_cnt
);

  localparam int OFF_W  = clog2(LINE_WORDS);
  localparam int IDX_W  = clog2(NUM_LINES);
  localparam int TAG_W  = WORD_SIZE - IDX_W - OFF_W;
  localparam int LINE_W = LINE_WORDS * WORD_SIZE;

  state_t                state;
  logic [OFF_W-1:0]      off;
  logic [IDX_W-1:0]      idx;
  logic [TAG_W-1:0]      tag;
  logic [TAG_W-1:0]      s_tag;
  logic                  s_valid;
  logic                  s_dirty;
  logic [LINE_W-1:0]     s_line;
  logic [LINE_W-1:0]     merged;
  logic [LINE_W-1:0]     wdata;
  logic [LINE_WORDS-1:0] word_we;
  logic                  tag_we;
  logic                  dirty_we;
  logic                  dirty_in;
  logic                  req;
  logic                  hit;
  logic                  ready;

  assign off = cpu.address[OFF_W-1:0];
  assign idx = cpu.address[OFF_W +: IDX_W];
  assign tag = cpu.address[WORD_SIZE-1 -: TAG_W];
  assign req = cpu.readC | cpu.writeC;
  assign hit = s_valid && (s_tag == tag);

  always_comb begin
    merged = s_line;
    merged[int'(off)*WORD_SIZE +: WORD_SIZE] = cpu.data_in;
  end

  // Store writes are suppressed while reset is held.
  always_comb begin
    word_we  = '0;
    wdata    = {LINE_WORDS{cpu.data_in}};
    tag_we   = 1'b0;
    dirty_we = 1'b0;
    dirty_in = 1'b0;
    if (reset_n) begin
      unique case (state)
        IDLE: if (req && hit && cpu.writeC) begin
          word_we[off] = 1'b1;
          dirty_we     = WRITE_BACK;
          dirty_in     = 1'b1;
        end
        EVICT: dirty_we = mem.readyM;
        FILL: if (mem.readyM) begin
          word_we  = '1;
          wdata    = mem.dataM_in;
          tag_we   = 1'b1;
          dirty_we = 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Write-through write hits finish in WTHRU, not in IDLE.
  always_comb begin
    ready = 1'b0;
    unique case (state)
      IDLE:  ready = req && hit && !(cpu.writeC && !WRITE_BACK);
      WTHRU: ready = req && mem.readyM;
      default: ;
    endcase
  end

  assign cpu.readyC   = ready;
  assign cpu.data_out = (cpu.readC && ready)
                      ? s_line[int'(off)*WORD_SIZE +: WORD_SIZE]
                      : '0;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state         <= IDLE;
      mem.readM     <= 1'b0;
      mem.writeM    <= 1'b0;
      mem.addressM  <= '0;
      mem.dataM_out <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (req && hit && cpu.writeC && !WRITE_BACK) begin
            state         <= WTHRU;
            mem.writeM    <= 1'b1;
            mem.addressM  <= {tag, idx, {OFF_W{1'b0}}};
            mem.dataM_out <= merged;
          end else if (req && !hit) begin
            if (WRITE_BACK && s_valid && s_dirty) begin
              state         <= EVICT;
              mem.writeM    <= 1'b1;
              mem.addressM  <= {s_tag, idx, {OFF_W{1'b0}}};
              mem.dataM_out <= s_line;
            end else begin
              state        <= FILL;
              mem.readM    <= 1'b1;
              mem.addressM <= {tag, idx, {OFF_W{1'b0}}};
            end
          end
        end
        EVICT: if (mem.readyM) begin
          state        <= FILL;
          mem.writeM   <= 1'b0;
          mem.readM    <= 1'b1;
          mem.addressM <= {tag, idx, {OFF_W{1'b0}}};
        end
        FILL: if (mem.readyM) begin
          state     <= IDLE;
          mem.readM <= 1'b0;
        end
        WTHRU: if (mem.readyM) begin
          state      <= IDLE;
          mem.writeM <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      access_cnt <= '0;
      miss_cnt   <= '0;
    end else begin
      if (ready && access_cnt != '1)
        access_cnt <= access_cnt + 1'b1;
      if (state == IDLE && req && !hit && miss_cnt != '1)
        miss_cnt <= miss_cnt + 1'b1;
    end
  end

  param_cache_store #(
    .WORD_SIZE (WORD_SIZE),
    .LINE_WORDS(LINE_WORDS),
    .NUM_LINES (NUM_LINES),
    .IDX_W     (IDX_W),
    .TAG_W     (TAG_W)
  ) u_store (
    .clk     (clk),
    .reset_n (reset_n),
    .idx     (idx),
    .word_we (word_we),
    .wdata   (wdata),
    .tag_we  (tag_we),
    .tag_in  (tag),
    .dirty_we(dirty_we),
    .dirty_in(dirty_in),
    .tag     (s_tag),
    .valid   (s_valid),
    .dirty   (s_dirty),
    .line    (s_line)
  );

endmodule

// File: tb/tb_param_cache.sv
// tb_param_cache: write-back (a) and write-through (b) caches on shared CPU stimulus.
// Reference: flat word memory for data, per-index tag table for hit/miss and traffic.
module tb_param_cache;

  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  param_cache_cpu_if #(.WORD_SIZE(16)) cpu_a ();
  param_cache_cpu_if #(.WORD_SIZE(16)) cpu_b ();
  param_cache_mem_if #(.WORD_SIZE(16), .LINE_WORDS(4)) mem_a ();
  param_cache_mem_if #(.WORD_SIZE(16), .LINE_WORDS(4)) mem_b ();

  logic [15:0] acc_a, miss_a;
  logic [2:0]  acc_b, miss_b;

  param_cache #(
    .WORD_SIZE(16), .LINE_WORDS(4), .NUM_LINES(4),
    .WRITE_BACK(1'b1), .CNT_W(16)
  ) dut_a (
    .clk(clk), .reset_n(reset_n), .cpu(cpu_a), .mem(mem_a),
    .access_cnt(acc_a), .miss_cnt(miss_a)
  );

  param_cache #(
    .WORD_SIZE(16), .LINE_WORDS(4), .NUM_LINES(4),
    .WRITE_BACK(1'b0), .CNT_W(3)
  ) dut_b (
    .clk(clk), .reset_n(reset_n), .cpu(cpu_b), .mem(mem_b),
    .access_cnt(acc_b), .miss_cnt(miss_b)
  );

  logic        rd, wr;
  logic [15:0] addr, din;
  logic [1:0]  done;

  assign cpu_a.readC   = rd & ~done[0];
  assign cpu_a.writeC  = wr & ~done[0];
  assign cpu_a.address = addr;
  assign cpu_a.data_in = din;
  assign cpu_b.readC   = rd & ~done[1];
  assign cpu_b.writeC  = wr & ~done[1];
  assign cpu_b.address = addr;
  assign cpu_b.data_in = din;

  logic [1:0]  rc;
  logic [15:0] dout [2];
  assign rc      = {cpu_b.readyC, cpu_a.readyC};
  assign dout[0] = cpu_a.data_out;
  assign dout[1] = cpu_b.data_out;

  logic [1:0]  rdm, wrm;
  logic [1:0]  rdy = 2'b00;
  logic [15:0] adm  [2];
  logic [63:0] dom  [2];
  logic [63:0] mdin [2];
  assign rdm = {mem_b.readM, mem_a.readM};
  assign wrm = {mem_b.writeM, mem_a.writeM};
  assign adm[0] = mem_a.addressM;
  assign adm[1] = mem_b.addressM;
  assign dom[0] = mem_a.dataM_out;
  assign dom[1] = mem_b.dataM_out;
  assign mem_a.readyM   = rdy[0];
  assign mem_a.dataM_in = mdin[0];
  assign mem_b.readyM   = rdy[1];
  assign mem_b.dataM_in = mdin[1];

  // Backing memories, word addressed; one line = 4 consecutive words.
  logic [15:0] mem [2][65536];
  logic [15:0] ref_mem [65536];
  int          wait_n [2] = '{0, 0};
  int          lat_max = 0;
  bit          hold_rd = 1'b0;
  int          n_rd [2] = '{0, 0};
  int          n_wr [2] = '{0, 0};
  logic [15:0] last_rd [2];
  logic [15:0] last_wr [2];
  logic [63:0] last_line [2];
  int          mbase;

  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      rdy[i] = 1'b0;
      if ((rdm[i] || wrm[i]) && !(rdm[i] && hold_rd)) begin
        if (wait_n[i] > 0) begin
          wait_n[i]--;
        end else begin
          rdy[i]    = 1'b1;
          wait_n[i] = $urandom_range(0, lat_max);
          mbase     = int'(adm[i]);
          if (wrm[i]) begin
            for (int k = 0; k < 4; k++)
              mem[i][mbase+k] = dom[i][k*16 +: 16];
            n_wr[i]++;
            last_wr[i]   = adm[i];
            last_line[i] = dom[i];
          end else begin
            for (int k = 0; k < 4; k++)
              mdin[i][k*16 +: 16] = mem[i][mbase+k];
            n_rd[i]++;
            last_rd[i] = adm[i];
          end
        end
      end
    end
  end

  int n_chk = 0;
  int n_err = 0;

  task automatic check(input string tag,
                       input logic [63:0] got,
                       input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  // Direct-mapped model: 4 lines of 4 words, tag = addr / 16.
  bit m_valid [4];
  bit m_dirty [4];
  int m_tag   [4];
  int m_miss, m_acc, m_evict, m_wt;
  int base_rd [2];
  int base_wr [2];

  function automatic void model_reset();
    for (int i = 0; i < 4; i++) begin
      m_valid[i] = 1'b0;
      m_dirty[i] = 1'b0;
      m_tag[i]   = 0;
    end
    m_miss = 0; m_acc = 0; m_evict = 0; m_wt = 0;
    for (int i = 0; i < 2; i++) begin
      base_rd[i] = n_rd[i];
      base_wr[i] = n_wr[i];
    end
  endfunction

  task automatic access(input bit w, input logic [15:0] a,
                        input logic [15:0] d,
                        output int lat_a, output int lat_b,
                        output logic [15:0] got_a,
                        output logic [15:0] got_b);
    bit          fin [2];
    int          lat [2];
    logic [15:0] got [2];
    int          cyc;
    @(negedge clk);
    rd = !w; wr = w; addr = a; din = d; done = 2'b00;
    fin = '{1'b0, 1'b0};
    lat = '{-1, -1};
    got = '{16'h0, 16'h0};
    cyc = 0;
    while (!(fin[0] && fin[1]) && cyc < 50) begin
      #2;
      for (int i = 0; i < 2; i++) begin
        if (!fin[i] && rc[i]) begin
          fin[i] = 1'b1;
          lat[i] = cyc;
          got[i] = dout[i];
        end
      end
      @(negedge clk);
      done = {fin[1], fin[0]};
      cyc++;
    end
    if (!(fin[0] && fin[1]))
      check("req_timeout", {fin[1], fin[0]}, 2'b11);
    rd = 1'b0; wr = 1'b0; done = 2'b00;
    lat_a = lat[0]; lat_b = lat[1];
    got_a = got[0]; got_b = got[1];
  endtask

  task automatic op(input bit w, input logic [15:0] a,
                    input logic [15:0] d);
    int          li, tg, ea, eb, la, lb;
    bit          hit, dty;
    logic [15:0] ga, gb;
    li  = (int'(a) / 4) % 4;
    tg  = int'(a) / 16;
    hit = m_valid[li] && m_tag[li] == tg;
    dty = m_valid[li] && m_dirty[li];
    ea  = hit ? 0 : (dty ? 3 : 2);
    eb  = hit ? (w ? 1 : 0) : (w ? 3 : 2);
    if (!hit) begin
      m_miss++;
      if (dty) m_evict++;
      m_valid[li] = 1'b1;
      m_tag[li]   = tg;
      m_dirty[li] = 1'b0;
    end
    if (w) begin
      m_dirty[li] = 1'b1;
      m_wt++;
    end
    m_acc++;
    access(w, a, d, la, lb, ga, gb);
    if (w) begin
      ref_mem[a] = d;
    end else begin
      check("rd_data_a", ga, ref_mem[a]);
      check("rd_data_b", gb, ref_mem[a]);
    end
    if (lat_max == 0) begin
      check("latency_a", la, ea);
      check("latency_b", lb, eb);
    end
  endtask

  logic [15:0] ra;
  logic [63:0] ln;
  int          nbad;

  initial begin
    for (int i = 0; i < 65536; i++) begin
      ref_mem[i] = 16'($urandom);
      mem[0][i]  = ref_mem[i];
      mem[1][i]  = ref_mem[i];
    end
    for (int k = 0; k < 4; k++) begin
      ref_mem[16+k] = 16'(10 + k);
      mem[0][16+k]  = 16'(10 + k);
      mem[1][16+k]  = 16'(10 + k);
    end
    rd = 1'b0; wr = 1'b0; addr = '0; din = '0; done = 2'b00;
    reset_n = 1'b0;
    repeat (2) @(negedge clk);
    #2;
    check("rst_readM",  rdm, 2'b00);
    check("rst_writeM", wrm, 2'b00);
    check("rst_addrM_a", adm[0], 16'h0);
    check("rst_dataM_a", dom[0], 64'h0);
    check("rst_cnt_a", {acc_a, miss_a}, 32'h0);
    check("rst_cnt_b", {acc_b, miss_b}, 6'h0);
    check("rst_readyC", rc, 2'b00);
    reset_n = 1'b1;
    model_reset();

    op(1'b0, 16'h0012, 16'h0);
    check("cold_fill_addr_a", last_rd[0], 16'h0010);
    check("cold_fill_addr_b", last_rd[1], 16'h0010);
    check("cold_miss_a", miss_a, 16'd1);
    op(1'b1, 16'h0012, 16'hBEEF);
    ln = last_line[1];
    check("wt_addr_b", last_wr[1], 16'h0010);
    check("wt_word2_b", ln[47:32], 16'hBEEF);
    op(1'b0, 16'h0012, 16'h0);
    check("wb_no_write_a", n_wr[0], 0);
    op(1'b0, 16'h0112, 16'h0);
    ln = last_line[0];
    check("evict_addr_a", last_wr[0], 16'h0010);
    check("evict_word2_a", ln[47:32], 16'hBEEF);
    check("refill_addr_a", last_rd[0], 16'h0110);
    op(1'b1, 16'h0113, 16'h1234);
    ln = last_line[1];
    check("wt_addr2_b", last_wr[1], 16'h0110);
    check("wt_word3_b", ln[63:48], 16'h1234);
    check("cnt_a", {acc_a, miss_a}, {16'd5, 16'd2});
    check("cnt_b", {acc_b, miss_b}, {3'd5, 3'd2});

    // Reset while the refill is outstanding.
    hold_rd = 1'b1;
    @(negedge clk);
    rd = 1'b1; addr = 16'h0220; done = 2'b00;
    repeat (3) @(negedge clk);
    #2;
    check("fill_pending", rdm, 2'b11);
    reset_n = 1'b0;
    @(negedge clk);
    #2;
    check("rst_fill_readM", rdm, 2'b00);
    check("rst_fill_writeM", wrm, 2'b00);
    check("rst_fill_cnt_a", {acc_a, miss_a}, 32'h0);
    check("rst_fill_cnt_b", {acc_b, miss_b}, 6'h0);
    rd = 1'b0; reset_n = 1'b1; hold_rd = 1'b0;
    model_reset();
    op(1'b0, 16'h0112, 16'h0);
    check("miss_after_rst_a", miss_a, 16'd1);

    for (int n = 0; n < 200; n++) begin
      ra = 16'($urandom) & 16'h003F;
      op($urandom_range(0, 1) == 1, ra, 16'($urandom));
    end
    lat_max = 2;
    for (int n = 0; n < 200; n++) begin
      ra = 16'($urandom) & 16'h003F;
      op($urandom_range(0, 1) == 1, ra, 16'($urandom));
    end
    @(negedge clk);
    #2;
    check("final_acc_a", acc_a, m_acc);
    check("final_miss_a", miss_a, m_miss);
    check("sat_acc_b", acc_b, (m_acc > 7) ? 7 : m_acc);
    check("sat_miss_b", miss_b, (m_miss > 7) ? 7 : m_miss);
    check("fills_a", n_rd[0] - base_rd[0], m_miss);
    check("fills_b", n_rd[1] - base_rd[1], m_miss);
    check("evicts_a", n_wr[0] - base_wr[0], m_evict);
    check("wthru_b", n_wr[1] - base_wr[1], m_wt);
    nbad = 0;
    for (int i = 0; i < 64; i++)
      if (mem[1][i] !== ref_mem[i]) nbad++;
    check("wt_coherent_b", nbad, 0);

    $display("Simulation finished: %0d checks, %0d errors",
             n_chk, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: run did not complete");
    $fatal(1, "watchdog expired");
  end

endmodule
